// File: rtl/dps_enc_37_seq_if.sv
// Handshake bundle for the 37-bit DPS (Fibonacci-weighted) encoder.
// Ports: in_valid/in_ready/in_data = word channel; out_valid/out_ready/out_code/out_err = result channel.
// Modports: slave = encoder side, master = word source / result sink side.
`ifndef FNS_VH
`define FNS_VH
`define DBLEN37 27
`define FNS01 28'd1
`define FNS02 28'd2
`define FNS03 28'd3
`define FNS04 28'd5
`define FNS05 28'd8
`define FNS06 28'd13
`define FNS07 28'd21
`define FNS08 28'd34
`define FNS09 28'd55
`define FNS10 28'd89
`define FNS11 28'd144
`define FNS12 28'd233
`define FNS13 28'd377
`define FNS14 28'd610
`define FNS15 28'd987
`define FNS16 28'd1597
`define FNS17 28'd2584
`define FNS18 28'd4181
`define FNS19 28'd6765
`define FNS20 28'd10946
`define FNS21 28'd17711
`define FNS22 28'd28657
`define FNS23 28'd46368
`define FNS24 28'd75025
`define FNS25 28'd121393
`define FNS26 28'd196418
`define FNS27 28'd317811
`define FNS28 28'd514229
`define FNS29 28'd832040
`define FNS30 28'd1346269
`define FNS31 28'd2178309
`define FNS32 28'd3524578
`define FNS33 28'd5702887
`define FNS34 28'd9227465
`define FNS35 28'd14930352
`define FNS36 28'd24157817
`define FNS37 28'd39088169
`endif

interface dps_enc_37_seq_if;
  logic                  in_valid;
  logic                  in_ready;
  logic [`DBLEN37-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [36:0]           out_code;
  logic                  out_err;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_err
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_err
  );
endinterface

// File: rtl/dps_enc_37_seq.sv
// Purpose: sequential greedy encoder of a binary word into a 37-bit DPS (Fibonacci-weighted) codeword.
// Latency: in-range word accepted at edge N -> out_valid after edge N+37; out-of-range -> after edge N+1.
// Backpressure: one word in flight; in_ready only in IDLE; result held stable until out_ready.
// Ports: clk, rst (sync, active-high); bus (slave modport): in_valid/in_ready/in_data,
//        out_valid/out_ready/out_code/out_err.
`ifndef FNS_VH
`define FNS_VH
`define DBLEN37 27
`define FNS01 28'd1
`define FNS02 28'd2
`define FNS03 28'd3
`define FNS04 28'd5
`define FNS05 28'd8
`define FNS06 28'd13
`define FNS07 28'd21
`define FNS08 28'd34
`define FNS09 28'd55
`define FNS10 28'd89
`define FNS11 28'd144
`define FNS12 28'd233
`define FNS13 28'd377
`define FNS14 28'd610
`define FNS15 28'd987
`define FNS16 28'd1597
`define FNS17 28'd2584
`define FNS18 28'd4181
`define FNS19 28'd6765
`define FNS20 28'd10946
`define FNS21 28'd17711
`define FNS22 28'd28657
`define FNS23 28'd46368
`define FNS24 28'd75025
`define FNS25 28'd121393
`define FNS26 28'd196418
`define FNS27 28'd317811
`define FNS28 28'd514229
`define FNS29 28'd832040
`define FNS30 28'd1346269
`define FNS31 28'd2178309
`define FNS32 28'd3524578
`define FNS33 28'd5702887
`define FNS34 28'd9227465
`define FNS35 28'd14930352
`define FNS36 28'd24157817
`define FNS37 28'd39088169
`endif

module dps_enc_37_seq (
  input  logic            clk,
  input  logic            rst,
  dps_enc_37_seq_if.slave bus
);

  // One spare bit so compare/subtract can never wrap.
  localparam int RW = `DBLEN37 + 1;
  localparam logic [RW-1:0] DMAX = `FNS36 + `FNS36 + `FNS37 + `FNS37 - 28'd2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [RW-1:0]   rem;
  logic [5:0]      step;
  logic [36:0]     code;
  logic            err;
  logic            vld;

  logic [5:0]      cur_bit;
  logic [RW-1:0]   cur_w;
  logic            take;
  logic            in_range;
  logic            last_step;

  // Resolution order: bit 35 (2*F36, the largest weight) first, then 36, then 34 down to 0.
  function automatic logic [5:0] bit_of(input logic [5:0] s);
    if (s == 6'd0)      return 6'd35;
    else if (s == 6'd1) return 6'd36;
    else                return 6'd36 - s;
  endfunction

  function automatic logic [RW-1:0] weight(input logic [5:0] b);
    case (b)
      6'd0:  return `FNS01;
      6'd1:  return `FNS02;
      6'd2:  return `FNS03;
      6'd3:  return `FNS04;
      6'd4:  return `FNS05;
      6'd5:  return `FNS06;
      6'd6:  return `FNS07;
      6'd7:  return `FNS08;
      6'd8:  return `FNS09;
      6'd9:  return `FNS10;
      6'd10: return `FNS11;
      6'd11: return `FNS12;
      6'd12: return `FNS13;
      6'd13: return `FNS14;
      6'd14: return `FNS15;
      6'd15: return `FNS16;
      6'd16: return `FNS17;
      6'd17: return `FNS18;
      6'd18: return `FNS19;
      6'd19: return `FNS20;
      6'd20: return `FNS21;
      6'd21: return `FNS22;
      6'd22: return `FNS23;
      6'd23: return `FNS24;
      6'd24: return `FNS25;
      6'd25: return `FNS26;
      6'd26: return `FNS27;
      6'd27: return `FNS28;
      6'd28: return `FNS29;
      6'd29: return `FNS30;
      6'd30: return `FNS31;
      6'd31: return `FNS32;
      6'd32: return `FNS33;
      6'd33: return `FNS34;
      6'd34: return `FNS35;
      6'd35: return `FNS36 + `FNS36;
      6'd36: return `FNS37;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    cur_bit   = bit_of(step);
    cur_w     = weight(cur_bit);
    take      = (rem >= cur_w);
    in_range  = ({1'b0, bus.in_data} <= DMAX);
    last_step = (step == 6'd36);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = in_range ? CALC : DONE;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (vld && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // out_valid is a register: a word reaching DONE from the last CALC step
  // presents immediately, while a rejected word spends its first DONE cycle
  // committing code=0/err=1 and presents one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      step <= '0;
      code <= '0;
      err  <= 1'b0;
      vld  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vld <= 1'b0;
          if (bus.in_valid) begin
            step <= '0;
            code <= '0;
            err  <= !in_range;
            rem  <= in_range ? {1'b0, bus.in_data} : '0;
          end
        end
        CALC: begin
          code[cur_bit] <= take;
          if (take) rem <= rem - cur_w;
          step <= step + 6'd1;
          vld  <= last_step;
        end
        DONE: begin
          if (vld && bus.out_ready) vld <= 1'b0;
          else                      vld <= 1'b1;
        end
        default: vld <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = vld;
  assign bus.out_code  = code;
  assign bus.out_err   = err;

endmodule
